// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit.
// Opcode/funct encodings, ALU op codes, mux select codes and the FSM state enum.
// Pure declarations; no logic, no timing.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // ALU B operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RST, S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_LW, S_BR, S_JMP
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// R-type funct decoder: maps func to an ALU operation plus a supported flag.
// Purely combinational, zero latency.
// No flow control.
module alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       valid
);

  // Unsupported functs report valid=0 and fall back to ADD
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (func)
      FN_ADDU: alu_op = ALU_ADD;
      FN_SUBU: alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM driving the shared PC/IR/regfile/ALU/memory datapath.
// 3-5 cycles per instruction at zero wait states; outputs are Moore from the state register.
// Memory states hold mem_req/mem_we/iord until mem_ready; IF write enables wait for mem_ready.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal
);

  state_t     state, state_nxt;
  logic       ill_set;
  logic [2:0] r_alu_op;
  logic       func_ok;

  alu_dec u_alu_dec (
    .func   (func),
    .alu_op (r_alu_op),
    .valid  (func_ok)
  );

  // State register and sticky illegal flag; reset overrides everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RST;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ill_set) illegal <= 1'b1;
    end
  end

  // Next-state and per-state control outputs; everything defaults to 0
  always_comb begin
    state_nxt  = state;
    ill_set    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    case (state)
      S_RST: state_nxt = S_IF;
      S_IF: begin
        // Fetch and PC+4 in the same cycle; both commit only when memory answers
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) state_nxt = S_ID;
      end
      S_ID: begin
        // ALUOut <= PC + (sext(imm) << 2): branch target ready for BR
        alu_src_b = SRCB_BROFF;
        case (op)
          OP_RTYPE: begin
            if (func_ok) state_nxt = S_EX_R;
            else begin
              state_nxt = S_IF;
              ill_set   = 1'b1;
            end
          end
          OP_ADDIU, OP_ORI: state_nxt = S_EX_I;
          OP_LW, OP_SW:     state_nxt = S_EX_ADR;
          OP_BEQ:           state_nxt = S_BR;
          OP_J:             state_nxt = S_JMP;
          default: begin
            state_nxt = S_IF;
            ill_set   = 1'b1;
          end
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        state_nxt = S_WB_R;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (op == OP_ORI) begin
          alu_op = ALU_OR;
        end else begin
          ext_op = 1'b1;
        end
        state_nxt = S_WB_I;
      end
      S_EX_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        if (op == OP_LW)      state_nxt = S_MEM_RD;
        else if (op == OP_SW) state_nxt = S_MEM_WR;
        else                  state_nxt = S_IF;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nxt = S_WB_LW;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nxt = S_IF;
      end
      S_WB_R: begin
        reg_we    = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_IF;
      end
      S_WB_I: begin
        reg_we    = 1'b1;
        state_nxt = S_IF;
      end
      S_WB_LW: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_IF;
      end
      S_BR: begin
        // A - B compare; PC takes the precomputed target only when equal
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = zero;
        state_nxt = S_IF;
      end
      S_JMP: begin
        pc_src    = PC_JUMP;
        pc_we     = 1'b1;
        state_nxt = S_IF;
      end
      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: cycle-by-cycle vector table plus instruction latency sequences.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_op, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op), .pc_src(pc_src),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b[1:0], ext_op, alu_op[2:0], pc_src[1:0]}
  logic [16:0] got;
  assign got = {mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, ext_op, alu_op, pc_src};

  localparam logic [16:0] E_RST     = 17'b0_0_0_0_0_0_0_0_0_00_0_000_00;
  localparam logic [16:0] E_IFW     = 17'b1_0_0_0_0_0_0_0_0_01_0_000_00;
  localparam logic [16:0] E_IFR     = 17'b1_0_0_1_1_0_0_0_0_01_0_000_00;
  localparam logic [16:0] E_ID      = 17'b0_0_0_0_0_0_0_0_0_11_0_000_00;
  localparam logic [16:0] E_EXR_ADD = 17'b0_0_0_0_0_0_0_0_1_00_0_000_00;
  localparam logic [16:0] E_EXR_SUB = 17'b0_0_0_0_0_0_0_0_1_00_0_001_00;
  localparam logic [16:0] E_EXR_AND = 17'b0_0_0_0_0_0_0_0_1_00_0_010_00;
  localparam logic [16:0] E_EXR_OR  = 17'b0_0_0_0_0_0_0_0_1_00_0_011_00;
  localparam logic [16:0] E_EXR_SLT = 17'b0_0_0_0_0_0_0_0_1_00_0_100_00;
  localparam logic [16:0] E_EXI_ADD = 17'b0_0_0_0_0_0_0_0_1_10_1_000_00;
  localparam logic [16:0] E_EXI_ORI = 17'b0_0_0_0_0_0_0_0_1_10_0_011_00;
  localparam logic [16:0] E_EXADR   = 17'b0_0_0_0_0_0_0_0_1_10_1_000_00;
  localparam logic [16:0] E_MRD     = 17'b1_0_1_0_0_0_0_0_0_00_0_000_00;
  localparam logic [16:0] E_MWR     = 17'b1_1_1_0_0_0_0_0_0_00_0_000_00;
  localparam logic [16:0] E_WBR     = 17'b0_0_0_0_0_1_1_0_0_00_0_000_00;
  localparam logic [16:0] E_WBI     = 17'b0_0_0_0_0_1_0_0_0_00_0_000_00;
  localparam logic [16:0] E_WBLW    = 17'b0_0_0_0_0_1_0_1_0_00_0_000_00;
  localparam logic [16:0] E_BRT     = 17'b0_0_0_0_1_0_0_0_1_00_0_001_01;
  localparam logic [16:0] E_BRN     = 17'b0_0_0_0_0_0_0_0_1_00_0_001_01;
  localparam logic [16:0] E_JMP     = 17'b0_0_0_0_1_0_0_0_0_00_0_000_10;

  typedef struct {
    string       nm;
    logic        rst;
    logic [5:0]  o;
    logic [5:0]  f;
    logic        z;
    logic        mr;
    logic [16:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic [16:0] e, input logic il);
    vec_t v;
    v.nm = nm; v.rst = r; v.o = o; v.f = f; v.z = z; v.mr = mr; v.exp = e; v.ill = il;
    vecs.push_back(v);
  endtask

  // One R-type at zero wait states: IF, ID, EX_R, WB_R
  task automatic add_rtype(input string nm, input logic [5:0] f, input logic [16:0] e_ex);
    add({nm, "_if"}, 1, 6'h2a, 6'h3f, 0, 1, E_IFR, 0);
    add({nm, "_id"}, 1, 6'h00, f, 0, 0, E_ID, 0);
    add({nm, "_ex"}, 1, 6'h00, f, 0, 0, e_ex, 0);
    add({nm, "_wb"}, 1, 6'h00, f, 0, 0, E_WBR, 0);
  endtask

  task automatic check(input string nm, input logic [16:0] g, input logic [16:0] e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, g, e);
    end
  endtask

  // Runs one instruction from IF until the next IF; memory-data phase sees `waits` not-ready cycles
  task automatic measure(input string nm, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input int waits, input int exp_cyc);
    int  cyc = 0;
    int  w = 0;
    bit  done = 0;
    while (!done && cyc < 50) begin
      op = o; func = f; zero = z;
      if (iord) begin
        mem_ready = (w >= waits);
        w++;
      end else begin
        mem_ready = 1'b1;
      end
      cyc++;
      @(posedge clk); #1;
      if (mem_req && !iord) done = 1;
    end
    check({nm, "_cycles"}, 17'(cyc), 17'(exp_cyc));
  endtask

  initial begin
    rst_n = 0; op = 0; func = 0; zero = 0; mem_ready = 0;

    // Reset and release
    add("rst_hold", 0, 6'h00, 6'h00, 0, 1, E_RST, 0);
    add("rst_rel",  1, 6'h00, 6'h00, 0, 0, E_RST, 0);
    // R-types, every funct
    add_rtype("addu", 6'b100001, E_EXR_ADD);
    add_rtype("subu", 6'b100011, E_EXR_SUB);
    add_rtype("and",  6'b100100, E_EXR_AND);
    add_rtype("or",   6'b100101, E_EXR_OR);
    add_rtype("slt",  6'b101010, E_EXR_SLT);
    // addiu / ori
    add("addiu_if", 1, 6'h3f, 6'h00, 0, 1, E_IFR, 0);
    add("addiu_id", 1, 6'b001001, 6'h00, 0, 0, E_ID, 0);
    add("addiu_ex", 1, 6'b001001, 6'h00, 0, 0, E_EXI_ADD, 0);
    add("addiu_wb", 1, 6'b001001, 6'h00, 0, 0, E_WBI, 0);
    add("ori_if",   1, 6'h00, 6'h00, 0, 1, E_IFR, 0);
    add("ori_id",   1, 6'b001101, 6'h00, 0, 0, E_ID, 0);
    add("ori_ex",   1, 6'b001101, 6'h00, 0, 0, E_EXI_ORI, 0);
    add("ori_wb",   1, 6'b001101, 6'h00, 0, 0, E_WBI, 0);
    // lw with two wait states in MEM_RD (7 cycles)
    add("lw_if",    1, 6'h00, 6'h00, 0, 1, E_IFR, 0);
    add("lw_id",    1, 6'b100011, 6'h00, 0, 0, E_ID, 0);
    add("lw_adr",   1, 6'b100011, 6'h00, 0, 0, E_EXADR, 0);
    add("lw_w1",    1, 6'b100011, 6'h00, 0, 0, E_MRD, 0);
    add("lw_w2",    1, 6'b100011, 6'h00, 0, 0, E_MRD, 0);
    add("lw_rdy",   1, 6'b100011, 6'h00, 0, 1, E_MRD, 0);
    add("lw_wb",    1, 6'b100011, 6'h00, 0, 0, E_WBLW, 0);
    // sw with one fetch wait; mem_ready outside requests is ignored
    add("sw_ifw",   1, 6'h00, 6'h00, 0, 0, E_IFW, 0);
    add("sw_ifr",   1, 6'h00, 6'h00, 0, 1, E_IFR, 0);
    add("sw_id",    1, 6'b101011, 6'h00, 0, 1, E_ID, 0);
    add("sw_adr",   1, 6'b101011, 6'h00, 0, 1, E_EXADR, 0);
    add("sw_wr",    1, 6'b101011, 6'h00, 0, 1, E_MWR, 0);
    // beq taken / not taken
    add("beqt_if",  1, 6'h00, 6'h00, 0, 1, E_IFR, 0);
    add("beqt_id",  1, 6'b000100, 6'h00, 0, 0, E_ID, 0);
    add("beqt_br",  1, 6'b000100, 6'h00, 1, 0, E_BRT, 0);
    add("beqn_if",  1, 6'h00, 6'h00, 1, 1, E_IFR, 0);
    add("beqn_id",  1, 6'b000100, 6'h00, 1, 0, E_ID, 0);
    add("beqn_br",  1, 6'b000100, 6'h00, 0, 0, E_BRN, 0);
    // j: next fetch in cycle 4
    add("j_if",     1, 6'h00, 6'h00, 0, 1, E_IFR, 0);
    add("j_id",     1, 6'b000010, 6'h00, 0, 0, E_ID, 0);
    add("j_jmp",    1, 6'b000010, 6'h00, 0, 0, E_JMP, 0);
    // R-type with unsupported funct: illegal rises after ID, fetch resumes
    add("badfn_if", 1, 6'h00, 6'h00, 0, 1, E_IFR, 0);
    add("badfn_id", 1, 6'h00, 6'h00, 0, 0, E_ID, 0);
    // sw interrupted by reset during a memory wait
    add("rsw_if",   1, 6'h00, 6'h00, 0, 1, E_IFR, 1);
    add("rsw_id",   1, 6'b101011, 6'h00, 0, 0, E_ID, 1);
    add("rsw_adr",  1, 6'b101011, 6'h00, 0, 0, E_EXADR, 1);
    add("rsw_w1",   1, 6'b101011, 6'h00, 0, 0, E_MWR, 1);
    add("rsw_rst",  0, 6'b101011, 6'h00, 0, 0, E_MWR, 1);
    add("rsw_st",   1, 6'b101011, 6'h00, 0, 1, E_RST, 0);
    // illegal opcode after reset cleared the flag
    add("badop_if", 1, 6'h00, 6'h00, 0, 1, E_IFR, 0);
    add("badop_id", 1, 6'b111111, 6'h00, 0, 0, E_ID, 0);
    add("badop_nx", 1, 6'h00, 6'h00, 0, 0, E_IFW, 1);

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst; op = vecs[i].o; func = vecs[i].f;
      zero = vecs[i].z; mem_ready = vecs[i].mr;
      #4;
      check(vecs[i].nm, got, vecs[i].exp);
      check({vecs[i].nm, "_illegal"}, {16'b0, illegal}, {16'b0, vecs[i].ill});
      @(posedge clk); #1;
    end

    // Whole-instruction latencies, starting in IF
    measure("j",      6'b000010, 6'h00,     0, 0, 3);
    measure("beq",    6'b000100, 6'h00,     1, 0, 3);
    measure("and",    6'b000000, 6'b100100, 0, 0, 4);
    measure("ori",    6'b001101, 6'h00,     0, 0, 4);
    measure("sw",     6'b101011, 6'h00,     0, 0, 4);
    measure("lw3w",   6'b100011, 6'h00,     0, 3, 8);
    measure("badop",  6'b110000, 6'h00,     0, 0, 2);
    check("illegal_sticky", {16'b0, illegal}, 17'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle MIPS control unit. It sequences the shared datapath (PC, IR, register file, one ALU, one unified memory port) across fetch, decode, execute, memory and write-back states. It is driven by the `op`/`func` fields that the instruction-field decoder extracts from the IR, and by the ALU `zero` flag. All datapath control outputs are Moore, decoded from the state register, except the two write enables that are qualified by `mem_ready`.

## Interface
Parameters:
- none. Opcode, funct and ALU-op encodings are fixed constants in the shared package.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `op`  in  6  IR[31:26], from the field decoder.
- `func`  in  6  IR[5:0], from the field decoder.
- `zero`  in  1  ALU result == 0.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held high until `mem_ready`.
- `mem_we`  out  1  write request; valid only with `mem_req`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_we`  out  1  IR load.
- `pc_we`  out  1  PC load.
- `reg_we`  out  1  register file write.
- `reg_dst`  out  1  write register select: 0 = Rt, 1 = Rd.
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = extended imm16, 11 = sign-extended imm16 << 2.
- `ext_op`  out  1  imm16 extension: 1 = sign, 0 = zero.
- `alu_op`  out  3  ALU operation: ADD 000, SUB 001, AND 010, OR 011, SLT 100.
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], Target, 2'b00}.
- `illegal`  out  1  sticky; set on an unsupported op/func; cleared only by reset.

## Operation
Supported instructions:
- R-type (op 000000) with funct addu 100001, subu 100011, and 100100, or 100101, slt 101010.
- addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.

States: RST, IF, ID, EX_R, EX_I, EX_ADR, MEM_RD, MEM_WR, WB_R, WB_I, WB_LW, BR, JMP. Outputs not listed for a state are 0.

- **RST:** entered whenever `rst_n` = 0. All outputs 0. Goes to IF on the first cycle with `rst_n` = 1.
- **IF:** `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00.
  - `ir_we` = `pc_we` = `mem_ready`.
  - Goes to ID on `mem_ready`; otherwise stays in IF.
- **ID:** `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (precomputes the branch target into ALUOut). Next state by `op`:
  - R-type → EX_R.
  - addiu, ori → EX_I.
  - lw, sw → EX_ADR.
  - beq → BR.
  - j → JMP.
  - Anything else, or an R-type with an unsupported funct → IF, `illegal` set, no register or memory write.
- **EX_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_op` = funct decode. → WB_R.
- **EX_I:** `alu_src_a`=1, `alu_src_b`=10.
  - addiu: `ext_op`=1, `alu_op`=ADD.
  - ori: `ext_op`=0, `alu_op`=OR.
  - → WB_I.
- **EX_ADR:** `alu_src_a`=1, `alu_src_b`=10, `ext_op`=1, `alu_op`=ADD. lw → MEM_RD; sw → MEM_WR.
- **MEM_RD:** `mem_req`=1, `iord`=1. → WB_LW on `mem_ready`; otherwise stays.
- **MEM_WR:** `mem_req`=1, `mem_we`=1, `iord`=1. → IF on `mem_ready`; otherwise stays.
- **WB_R:** `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. → IF.
- **WB_I:** `reg_we`=1, `reg_dst`=0, `mem_to_reg`=0. → IF.
- **WB_LW:** `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. → IF.
- **BR:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=SUB, `pc_src`=01, `pc_we` = `zero`. → IF.
- **JMP:** `pc_src`=10, `pc_we`=1. → IF.

## Timing
- **Latency at zero wait states** (`mem_ready` high in the first request cycle), including IF:
  - R-type: 4 cycles.
  - addiu/ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
- **Wait states:** each memory wait cycle adds one cycle. `mem_req`, `mem_we` and `iord` stay stable while waiting. `ir_we`/`pc_we` in IF are never asserted before `mem_ready`.
- **Decode window:** `op`/`func` are sampled only in ID and EX states. They are undefined during IF.
- **Reset mid-operation:** `rst_n` low in any state, including a pending memory wait, forces RST on the next edge. `mem_req` drops that cycle and no write enable pulses.
- **`mem_ready` outside a request:** ignored.
- **`illegal`:** rises on the cycle after ID detects the fault and stays high.

## Structure
- Package `mips_ctrl_pkg`: opcode and funct constants, the `alu_op` encodings, the `alu_src_b`/`pc_src` select encodings, and the state enum.
- Sub-module `alu_dec`: combinational `func` → `alu_op`/valid, used in EX_R and for the illegal check in ID.

## Test plan
- **addu at zero wait:** op=000000, func=100001, `mem_ready`=1 → states IF, ID, EX_R, WB_R. `reg_we`=1 with `reg_dst`=1 in cycle 4. `pc_we` only in cycle 1.
- **lw with 2 wait states:** op=100011, `mem_ready` low for 2 cycles in MEM_RD → `mem_req`=1 and `iord`=1 held 3 cycles. WB_LW asserts `mem_to_reg`=1. Total 7 cycles.
- **beq taken and not taken:** op=000100, `zero`=1 → `pc_we`=1 with `pc_src`=01 in BR. `zero`=0 → `pc_we`=0. Both return to IF.
- **j:** op=000010 → JMP with `pc_we`=1, `pc_src`=10. Next instruction fetch starts in cycle 4.
- **Illegal instructions:** op=111111, and separately an R-type with func=000000 → `illegal` goes to 1 and stays. No `reg_we`/`mem_we`. Fetch resumes.
- **Reset during a memory wait:** `rst_n`=0 during MEM_WR with `mem_ready`=0 → next cycle all outputs 0. IF is re-entered one cycle after `rst_n` returns to 1. `illegal` is cleared.
